// File: rtl/mem_access_unit_pkg.sv
// Shared width codes, MMIO offsets and FSM encoding for the data-memory stage.
// No logic, no latency, no backpressure: constants and pure decode helpers only.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_SW_OFF  = 32'h0;
    localparam logic [31:0] MMIO_LED_OFF = 32'h4;
    localparam logic [31:0] MMIO_SEG_OFF = 32'h8;
    localparam logic [31:0] MMIO_SPAN    = 32'hC;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Unsigned widths only exist for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: return !lane[0];
            F3_W:        return lane == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the data-memory stage.
// Latency and backpressure are defined by the unit: stall holds the requester.
interface mem_access_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        access_err;

    modport master (
        output mem_read, mem_write, funct3, addr, store_data,
        input  load_data, stall, access_err
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, store_data,
        output load_data, stall, access_err
    );
endinterface

// File: rtl/mem_access_unit_load_align_ext.sv
// Selects the addressed byte/half of a RAM word and sign/zero-extends it.
// Purely combinational, zero latency, no backpressure.
module mem_access_unit_load_align_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        result = '0;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            F3_W:    result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: RAM loads/stores with lane alignment plus switch/LED/7-seg MMIO.
// RAM loads stall RAM_LATENCY cycles; stores and MMIO accesses complete in the same cycle.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int          RAM_AW      = 12,
    parameter int          RAM_LATENCY = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFFFC00
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  core,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic [31:0]       seg_out
);

    localparam logic [1:0] CNT_INIT = 2'(RAM_LATENCY - 1);

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [RAM_AW-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [15:0]       sw_meta, sw_sync;

    logic        rd, wr, in_ram, in_mmio, req_err;
    logic        ram_ld, ram_st, mmio_ld, mmio_st, issue;
    logic [31:0] mmio_off, mmio_rdata, ext_data, load_c;
    logic [3:0]  we_mask, we_c;
    logic        stall_c, err_c, en_c;

    // Request decode: region, width legality, alignment.
    always_comb begin
        rd       = core.mem_read;
        wr       = core.mem_write;
        in_ram   = (core.addr >> (RAM_AW + 2)) == 32'h0;
        mmio_off = core.addr - MMIO_BASE;
        in_mmio  = mmio_off < MMIO_SPAN;
        req_err  = (rd || wr) && ((rd && wr)
                   || !f3_legal(core.funct3, wr)
                   || !f3_aligned(core.funct3, core.addr[1:0])
                   || !(in_ram || in_mmio)
                   || (in_mmio && core.funct3 != F3_W)
                   || (in_mmio && wr && mmio_off == MMIO_SW_OFF));
        ram_ld   = rd && !wr && in_ram  && !req_err;
        ram_st   = wr && !rd && in_ram  && !req_err;
        mmio_ld  = rd && !wr && in_mmio && !req_err;
        mmio_st  = wr && !rd && in_mmio && !req_err;
    end

    always_comb begin
        we_mask   = 4'b0000;
        ram_wdata = core.store_data;
        case (core.funct3)
            F3_B: begin
                we_mask   = 4'b0001 << core.addr[1:0];
                ram_wdata = {4{core.store_data[7:0]}};
            end
            F3_H: begin
                we_mask   = 4'b0011 << {core.addr[1], 1'b0};
                ram_wdata = {2{core.store_data[15:0]}};
            end
            F3_W:    we_mask = 4'b1111;
            default: we_mask = 4'b0000;
        endcase

        case (mmio_off[3:2])
            2'd0:    mmio_rdata = {16'h0, sw_sync};
            2'd1:    mmio_rdata = {16'h0, led_out};
            2'd2:    mmio_rdata = seg_out;
            default: mmio_rdata = 32'h0;
        endcase
    end

    mem_access_unit_load_align_ext u_align (
        .rdata  (ram_rdata),
        .funct3 (f3_q),
        .lane   (lane_q),
        .result (ext_data)
    );

    // A dropped mem_read while waiting is a flush: the cycle is handled as a fresh request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        err_c     = 1'b0;
        en_c      = 1'b0;
        we_c      = 4'b0000;
        ram_addr  = core.addr[RAM_AW+1:2];
        load_c    = 32'h0;
        issue     = 1'b0;
        if (state == WAIT && rd) begin
            en_c     = 1'b1;
            ram_addr = addr_q;
            if (cnt != 2'd0) begin
                stall_c = 1'b1;
                cnt_nxt = cnt - 2'd1;
            end else begin
                load_c    = ext_data;
                state_nxt = IDLE;
            end
        end else begin
            state_nxt = IDLE;
            err_c     = req_err;
            if (ram_ld) begin
                en_c      = 1'b1;
                stall_c   = 1'b1;
                issue     = 1'b1;
                cnt_nxt   = CNT_INIT;
                state_nxt = WAIT;
            end
            if (ram_st) begin
                en_c = 1'b1;
                we_c = we_mask;
            end
            if (mmio_ld) begin
                load_c = mmio_rdata;
            end
        end
    end

    assign core.stall      = rst_n & stall_c;
    assign core.access_err = rst_n & err_c;
    assign core.load_data  = load_c;
    assign ram_en          = rst_n & en_c;
    assign ram_we          = rst_n ? we_c : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            addr_q <= '0;
            f3_q   <= 3'b000;
            lane_q <= 2'b00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (issue) begin
                addr_q <= core.addr[RAM_AW+1:2];
                f3_q   <= core.funct3;
                lane_q <= core.addr[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= 16'h0;
            sw_sync <= 16'h0;
            led_out <= 16'h0;
            seg_out <= 32'h0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
            if (mmio_st && mmio_off == MMIO_LED_OFF) begin
                led_out <= core.store_data[15:0];
            end
            if (mmio_st && mmio_off == MMIO_SEG_OFF) begin
                seg_out <= core.store_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one DUT at RAM_LATENCY=1, one at RAM_LATENCY=2.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst1_n;
    logic        ram_en0, ram_en1;
    logic [3:0]  ram_we0, ram_we1;
    logic [11:0] ram_addr0, ram_addr1;
    logic [31:0] ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;
    logic [15:0] sw_in, led0, led1;
    logic [31:0] seg0, seg1;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit_if bus0();
    mem_access_unit_if bus1();

    mem_access_unit #(.RAM_AW(12), .RAM_LATENCY(1), .MMIO_BASE(32'hFFFFFC00)) u0 (
        .clk(clk), .rst_n(rst_n), .core(bus0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0), .sw_in(sw_in), .led_out(led0), .seg_out(seg0)
    );

    mem_access_unit #(.RAM_AW(12), .RAM_LATENCY(2), .MMIO_BASE(32'hFFFFFC00)) u1 (
        .clk(clk), .rst_n(rst1_n), .core(bus1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .sw_in(sw_in), .led_out(led1), .seg_out(seg1)
    );

    task automatic idle_inputs();
        bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.funct3 = 3'b010;
        bus0.addr = 32'h0;    bus0.store_data = 32'h0;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.funct3 = 3'b010;
        bus1.addr = 32'h0;    bus1.store_data = 32'h0;
    endtask

    // Issues one RAM load and returns the result plus the number of stalled cycles (8 = never finished).
    task automatic do_load(input bit which, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, output logic [31:0] ld, output int stalls);
        @(negedge clk);
        if (which) begin
            bus1.mem_read = 1'b1; bus1.funct3 = f3; bus1.addr = a; ram_rdata1 = rdata;
        end else begin
            bus0.mem_read = 1'b1; bus0.funct3 = f3; bus0.addr = a; ram_rdata0 = rdata;
        end
        stalls = 0;
        ld = 32'hx;
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((which ? bus1.stall : bus0.stall) === 1'b0) begin
                ld = which ? bus1.load_data : bus0.load_data;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; rst1_n = 1'b0; sw_in = 16'h0;
        ram_rdata0 = 32'h0; ram_rdata1 = 32'h0;
        bus0.mem_read = 1'b1; bus0.mem_write = 1'b1; bus0.addr = 32'h100;
        bus1.mem_read = 1'b1; bus1.addr = 32'h100;
        #2;
        n_cmp++; if (bus0.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus0.stall); end
        n_cmp++; if (bus0.access_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus0.access_err); end
        n_cmp++; if (ram_en0 !== 1'b0) begin n_bad++; $display("FAIL reset_ram_en: got %b want 0", ram_en0); end
        n_cmp++; if (ram_we0 !== 4'h0) begin n_bad++; $display("FAIL reset_ram_we: got %h want 0", ram_we0); end
        n_cmp++; if (led0 !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want 0", led0); end
        n_cmp++; if (seg0 !== 32'h0) begin n_bad++; $display("FAIL reset_seg: got %h want 0", seg0); end
        n_cmp++; if (bus1.stall !== 1'b0 || ram_en1 !== 1'b0) begin n_bad++;
            $display("FAIL reset_lat2: stall %b ram_en %b want 0 0", bus1.stall, ram_en1); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1; rst1_n = 1'b1;
    endtask

    task automatic test_lw_issue();
        @(negedge clk);
        bus0.mem_read = 1'b1; bus0.funct3 = 3'b010; bus0.addr = 32'h100; ram_rdata0 = 32'h8899AABB;
        #1;
        n_cmp++; if (ram_en0 !== 1'b1 || bus0.stall !== 1'b1) begin n_bad++;
            $display("FAIL lw_issue: ram_en %b stall %b want 1 1", ram_en0, bus0.stall); end
        n_cmp++; if (ram_addr0 !== 12'h040) begin n_bad++; $display("FAIL lw_addr: got %h want 040", ram_addr0); end
        n_cmp++; if (bus0.access_err !== 1'b0) begin n_bad++; $display("FAIL lw_err: got %b want 0", bus0.access_err); end
        @(negedge clk); #1;
        n_cmp++; if (bus0.stall !== 1'b0) begin n_bad++; $display("FAIL lw_done_stall: got %b want 0", bus0.stall); end
        n_cmp++; if (bus0.load_data !== 32'h8899AABB) begin n_bad++;
            $display("FAIL lw_data: got %h want 8899aabb", bus0.load_data); end
        idle_inputs();
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b000};
        logic [31:0] a   [7] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100, 32'h100};
        logic [31:0] exp [7] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB,
                                 32'hFFFFFFAA, 32'h000000BB, 32'hFFFFFFBB};
        logic [31:0] ld;
        int st;
        for (int i = 0; i < 7; i++) begin
            do_load(1'b0, f3[i], a[i], 32'h8899AABB, ld, st);
            n_cmp++; if (ld !== exp[i] || st != 1) begin n_bad++;
                $display("FAIL load_ext[%0d]: data %h stalls %0d want %h 1", i, ld, st, exp[i]); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3  [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] a   [5] = '{32'h102, 32'h101, 32'h103, 32'h104, 32'h100};
        logic [31:0] d   [5] = '{32'h00001234, 32'h000000AB, 32'h000000CD, 32'hDEADBEEF, 32'h0000BEEF};
        logic [3:0]  we  [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        logic [31:0] wd  [5] = '{32'h12341234, 32'hABABABAB, 32'hCDCDCDCD, 32'hDEADBEEF, 32'hBEEFBEEF};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus0.mem_write = 1'b1; bus0.funct3 = f3[i]; bus0.addr = a[i]; bus0.store_data = d[i];
            #1;
            n_cmp++; if (ram_we0 !== we[i]) begin n_bad++; $display("FAIL store_we[%0d]: got %b want %b", i, ram_we0, we[i]); end
            n_cmp++; if (ram_wdata0 !== wd[i]) begin n_bad++; $display("FAIL store_wdata[%0d]: got %h want %h", i, ram_wdata0, wd[i]); end
            n_cmp++; if (bus0.stall !== 1'b0 || bus0.access_err !== 1'b0 || ram_en0 !== 1'b1) begin n_bad++;
                $display("FAIL store_ctl[%0d]: stall %b err %b en %b want 0 0 1", i, bus0.stall, bus0.access_err, ram_en0); end
            idle_inputs();
        end
    endtask

    task automatic test_mmio();
        sw_in = 16'h5A5A;
        @(negedge clk);
        bus0.mem_write = 1'b1; bus0.funct3 = 3'b010; bus0.addr = 32'hFFFFFC04; bus0.store_data = 32'h1111ABCD;
        #1;
        n_cmp++; if (ram_en0 !== 1'b0 || bus0.access_err !== 1'b0 || bus0.stall !== 1'b0) begin n_bad++;
            $display("FAIL mmio_led_wr: en %b err %b stall %b want 0 0 0", ram_en0, bus0.access_err, bus0.stall); end
        n_cmp++; if (led0 !== 16'h0) begin n_bad++; $display("FAIL mmio_led_early: got %h want 0", led0); end
        @(negedge clk);
        idle_inputs();
        bus0.mem_read = 1'b1; bus0.addr = 32'hFFFFFC04;
        #1;
        n_cmp++; if (led0 !== 16'hABCD) begin n_bad++; $display("FAIL mmio_led: got %h want abcd", led0); end
        n_cmp++; if (bus0.load_data !== 32'h0000ABCD || bus0.stall !== 1'b0) begin n_bad++;
            $display("FAIL mmio_led_rd: data %h stall %b want 0000abcd 0", bus0.load_data, bus0.stall); end
        @(negedge clk);
        idle_inputs();
        bus0.mem_write = 1'b1; bus0.addr = 32'hFFFFFC08; bus0.store_data = 32'h12345678;
        @(negedge clk);
        idle_inputs();
        bus0.mem_read = 1'b1; bus0.addr = 32'hFFFFFC08;
        #1;
        n_cmp++; if (seg0 !== 32'h12345678 || bus0.load_data !== 32'h12345678) begin n_bad++;
            $display("FAIL mmio_seg: reg %h read %h want 12345678", seg0, bus0.load_data); end
        @(negedge clk);
        bus0.addr = 32'hFFFFFC00;
        #1;
        n_cmp++; if (bus0.load_data !== 32'h00005A5A) begin n_bad++;
            $display("FAIL mmio_sw_rd: got %h want 00005a5a", bus0.load_data); end
        @(negedge clk);
        idle_inputs();
        bus0.mem_write = 1'b1; bus0.addr = 32'hFFFFFC00; bus0.store_data = 32'h00000001;
        #1;
        n_cmp++; if (bus0.access_err !== 1'b1) begin n_bad++; $display("FAIL mmio_sw_store: err %b want 1", bus0.access_err); end
        @(negedge clk);
        idle_inputs();
        bus0.mem_read = 1'b1; bus0.funct3 = 3'b000; bus0.addr = 32'hFFFFFC04;
        #1;
        n_cmp++; if (bus0.access_err !== 1'b1 || bus0.load_data !== 32'h0) begin n_bad++;
            $display("FAIL mmio_lb: err %b data %h want 1 0", bus0.access_err, bus0.load_data); end
        n_cmp++; if (led0 !== 16'hABCD) begin n_bad++; $display("FAIL mmio_led_kept: got %h want abcd", led0); end
        idle_inputs();
    endtask

    task automatic test_errors();
        logic        rd [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        wr [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [8] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] a  [8] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h4000, 32'h100, 32'h100, 32'hFFFFFC0C};
        logic [31:0] ld;
        int st;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus0.mem_read = rd[i]; bus0.mem_write = wr[i]; bus0.funct3 = f3[i];
            bus0.addr = a[i]; bus0.store_data = 32'hFFFFFFFF; ram_rdata0 = 32'h8899AABB;
            #1;
            n_cmp++; if (bus0.access_err !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d]: got %b want 1", i, bus0.access_err); end
            n_cmp++; if (ram_en0 !== 1'b0 || ram_we0 !== 4'h0 || bus0.stall !== 1'b0) begin n_bad++;
                $display("FAIL err_noaccess[%0d]: en %b we %h stall %b want 0 0 0", i, ram_en0, ram_we0, bus0.stall); end
            n_cmp++; if (bus0.load_data !== 32'h0) begin n_bad++; $display("FAIL err_data[%0d]: got %h want 0", i, bus0.load_data); end
            idle_inputs();
        end
        do_load(1'b0, 3'b010, 32'h3FFC, 32'h01020304, ld, st);
        n_cmp++; if (ld !== 32'h01020304 || st != 1) begin n_bad++;
            $display("FAIL ram_top_word: data %h stalls %0d want 01020304 1", ld, st); end
    endtask

    task automatic test_lat2_flush();
        logic [31:0] ld;
        int st;
        do_load(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, ld, st);
        n_cmp++; if (ld !== 32'hCAFEF00D || st != 2) begin n_bad++;
            $display("FAIL lat2_load: data %h stalls %0d want cafef00d 2", ld, st); end
        @(negedge clk);
        bus1.mem_read = 1'b1; bus1.funct3 = 3'b010; bus1.addr = 32'h200;
        #1;
        n_cmp++; if (bus1.stall !== 1'b1) begin n_bad++; $display("FAIL flush_issue: stall %b want 1", bus1.stall); end
        @(negedge clk);
        bus1.mem_read = 1'b0;
        #1;
        n_cmp++; if (bus1.stall !== 1'b0 || ram_en1 !== 1'b0) begin n_bad++;
            $display("FAIL flush_abort: stall %b en %b want 0 0", bus1.stall, ram_en1); end
        do_load(1'b1, 3'b101, 32'h202, 32'h8001F00D, ld, st);
        n_cmp++; if (ld !== 32'h00008001 || st != 2) begin n_bad++;
            $display("FAIL flush_retry: data %h stalls %0d want 00008001 2", ld, st); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] ld;
        int st;
        @(negedge clk);
        bus1.mem_read = 1'b1; bus1.funct3 = 3'b010; bus1.addr = 32'h300; ram_rdata1 = 32'h55AA55AA;
        @(negedge clk); #1;
        n_cmp++; if (bus1.stall !== 1'b1) begin n_bad++; $display("FAIL rst_wait_stall2: got %b want 1", bus1.stall); end
        rst1_n = 1'b0;
        #1;
        n_cmp++; if (bus1.stall !== 1'b0 || ram_en1 !== 1'b0) begin n_bad++;
            $display("FAIL rst_wait_abort: stall %b en %b want 0 0", bus1.stall, ram_en1); end
        idle_inputs();
        @(negedge clk);
        rst1_n = 1'b1;
        do_load(1'b1, 3'b010, 32'h300, 32'h55AA55AA, ld, st);
        n_cmp++; if (ld !== 32'h55AA55AA || st != 2) begin n_bad++;
            $display("FAIL rst_wait_retry: data %h stalls %0d want 55aa55aa 2", ld, st); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw_issue();
        test_load_extend();
        test_store();
        test_mmio();
        test_errors();
        test_lat2_flush();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
